led_tx_scheduler: RTL and testbench
===================================

# led_tx_scheduler

Shares the single D-PPM LED encoder between several transmit requesters. It arbitrates round-robin, latches the winning frame and drives the encoder's `start`/`data` inputs. It then holds `start` until the encoder raises `irq`, releases the encoder cleanly and enforces an inter-frame gap before the next grant. It sits between the packet sources (framer, beacon, test pattern) and the encoder.

## Interface
- `ID_WIDTH`, 2, requester index width; `NUM_REQ = 1 << ID_WIDTH` requesters.
- `GAP_CYCLES`, 16, idle clocks between frames (LED dark); 16-bit value, 0 allowed.
- `TIMEOUT_CYCLES`, 65535, max clocks in SEND before abort (only with `TX_SCHED_TIMEOUT_EN`); 20-bit value.
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester transmit request, level.
- `frame_in`  in  NUM_REQ*FRAME_SIZE  requester i frame at bits [i*FRAME_SIZE +: FRAME_SIZE].
- `ack`  out  NUM_REQ  one-cycle pulse: frame of requester i fully encoded.
- `err`  out  NUM_REQ  one-cycle pulse: frame of requester i aborted by timeout.
- `enc_start`  out  1  to encoder `start`.
- `enc_data`  out  FRAME_SIZE  to encoder `data`, registered.
- `enc_irq`  in  1  from encoder `irq`.
- `grant_id`  out  ID_WIDTH  index of current/last granted requester.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Reset (async, `reset`=0): state IDLE, `enc_start`=0, `enc_data`=0, `ack`=0, `err`=0, `grant_id`=0, `busy`=0, rr pointer=0, counters=0.
- IDLE: if any `req` bit set, pick first set bit searching from rr pointer upward with wrap. On that edge: `enc_data`<=frame slice, `grant_id`<=winner, `enc_start`<=1, rr pointer<=winner+1 (mod NUM_REQ), go SEND. No request: stay.
- SEND: hold `enc_start`=1, `enc_data` stable. On `enc_irq`=1: `enc_start`<=0, `ack[grant_id]`<=1 for one cycle, go RELEASE.
- RELEASE: wait for `enc_irq`=0 (encoder clears it the cycle after seeing `start`=0). Then load gap counter with GAP_CYCLES and go GAP; if GAP_CYCLES=0 go IDLE directly.
- GAP: decrement each cycle; at 1 go IDLE. Requests are not sampled in GAP or RELEASE.
- Frame is sampled only at the grant edge; later `frame_in` changes do not affect the frame in flight. A requester drops `req` in the cycle it sees `ack`; a `req` still high in IDLE re-arbitrates as a new frame.
- `req` deasserted after grant: frame still sent, `ack` still pulses.
- Only one of `ack`/`err` pulses per grant, never both.

## Timing
- `req` rise in IDLE -> `enc_start`=1: 1 clock.
- `enc_irq` rise -> `enc_start`=0 and `ack` pulse: same edge, 1 clock.
- `ack` -> next possible `enc_start`: 1 (RELEASE min) + GAP_CYCLES + 1 clocks.
- All outputs registered; `busy` decoded from state register.
- Reset mid-SEND: `enc_start` drops asynchronously; encoder returns to its idle state; no `ack`/`err` issued.

## Configuration
- `TX_SCHED_TIMEOUT_EN` defined: a 20-bit SEND counter clears on entry to SEND. If it reaches TIMEOUT_CYCLES with `enc_irq` still 0: `enc_start`<=0, `err[grant_id]` pulse, go RELEASE. An `enc_irq`=1 on the timeout cycle itself wins (ack, not err).
- Undefined: SEND waits indefinitely for `enc_irq`; `err` tied to 0 (port retained).

## Structure
- `definitions.v` (shared) gains the state encodings (`TXS_IDLE`, `TXS_SEND`, `TXS_RELEASE`, `TXS_GAP`) and default `TX_GAP_CYCLES`. It already supplies `FRAME_SIZE` and the LED constants.
- Sub-module `rr_arbiter`: combinational round-robin pick (inputs `req`, pointer; outputs `valid`, `winner`). The pointer register lives in the scheduler.

## Test plan
- FRAME_SIZE frame 0xA5.. on req[1] only -> `enc_start` 1 clock later with `enc_data`=req1 frame; encoder `irq` -> `ack`=4'b0010 single pulse, `busy` low after GAP_CYCLES+2.
- req=4'b1111 held, each dropped on its ack -> grant order 0,1,2,3; the next batch restarts at the pointer; 16 idle clocks between consecutive `enc_start` rises.
- req[2] pulsed 1 cycle in IDLE, `frame_in` changed after grant -> encoded frame equals the value at grant edge; `ack[2]` still pulses.
- `reset` low mid-SEND -> `enc_start`=0 immediately, no `ack`; after release, pending req[0] granted normally with pointer=0.
- `TX_SCHED_TIMEOUT_EN`, TIMEOUT_CYCLES=100, encoder `irq` stuck 0 -> `err[grant_id]` pulse at cycle 100, `enc_start` low, no `ack`; without macro -> `enc_start` stays high.
- GAP_CYCLES=0 -> `enc_start` re-rises 2 clocks after `ack` when another request is pending.

Source files
------------

// File: rtl/led_tx_scheduler_pkg.sv
// Shared types and constants for the LED transmit scheduler: frame width,
// default inter-frame gap and the scheduler state encoding.
package led_tx_scheduler_pkg;

  localparam int FRAME_SIZE    = 16;
  localparam int TX_GAP_CYCLES = 16;

  typedef enum logic [1:0] {
    TXS_IDLE    = 2'd0,
    TXS_SEND    = 2'd1,
    TXS_RELEASE = 2'd2,
    TXS_GAP     = 2'd3
  } txs_state_e;

endpackage

// File: rtl/led_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module led_tx_scheduler_rr_arbiter #(
  parameter int ID_WIDTH = 2
) (
  input  logic [(1<<ID_WIDTH)-1:0] req,
  input  logic [ID_WIDTH-1:0]      ptr,
  output logic                     valid,
  output logic [ID_WIDTH-1:0]      winner
);

  localparam int NUM_REQ = 1 << ID_WIDTH;

  logic                found;
  logic [ID_WIDTH-1:0] idx;

  always_comb begin
    valid  = |req;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + ID_WIDTH'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_tx_scheduler.sv
// Shares one D-PPM LED encoder between round-robin requesters with a dark gap
// between frames. Define TX_SCHED_TIMEOUT_EN to abort stuck frames via err.
module led_tx_scheduler
  import led_tx_scheduler_pkg::*;
#(
  parameter int ID_WIDTH       = 2,
  parameter int GAP_CYCLES     = TX_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [(1<<ID_WIDTH)-1:0]            req,
  input  logic [(1<<ID_WIDTH)*FRAME_SIZE-1:0] frame_in,
  output logic [(1<<ID_WIDTH)-1:0]            ack,
  output logic [(1<<ID_WIDTH)-1:0]            err,
  output logic                                enc_start,
  output logic [FRAME_SIZE-1:0]               enc_data,
  input  logic                                enc_irq,
  output logic [ID_WIDTH-1:0]                 grant_id,
  output logic                                busy
);

  localparam int          NUM_REQ = 1 << ID_WIDTH;
  localparam logic [15:0] GAP_LD  = 16'(GAP_CYCLES);

  txs_state_e              state_q, state_d;
  logic                    start_q, start_d;
  logic [FRAME_SIZE-1:0]   data_q, data_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [15:0]             gap_q, gap_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    arb_valid;
  logic [ID_WIDTH-1:0]     arb_winner;
  logic [FRAME_SIZE-1:0]   frame_sel;
`ifdef TX_SCHED_TIMEOUT_EN
  localparam logic [19:0]  TO_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0]             to_q, to_d;
  logic [NUM_REQ-1:0]      err_q, err_d;
`endif

  led_tx_scheduler_rr_arbiter #(
    .ID_WIDTH (ID_WIDTH)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

  always_comb begin
    frame_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_winner == ID_WIDTH'(i)) frame_sel = frame_in[i*FRAME_SIZE +: FRAME_SIZE];
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    ack_d   = '0;
`ifdef TX_SCHED_TIMEOUT_EN
    to_d    = to_q;
    err_d   = '0;
`endif
    case (state_q)
      TXS_IDLE: begin
        if (arb_valid) begin
          data_d  = frame_sel;
          grant_d = arb_winner;
          start_d = 1'b1;
          ptr_d   = arb_winner + 1'b1;
          state_d = TXS_SEND;
`ifdef TX_SCHED_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      TXS_SEND: begin
        // An irq on the timeout cycle itself still completes as a normal ack.
        if (enc_irq) begin
          start_d        = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = TXS_RELEASE;
        end
`ifdef TX_SCHED_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          start_d        = 1'b0;
          err_d[grant_q] = 1'b1;
          state_d        = TXS_RELEASE;
        end else begin
          to_d = to_q + 20'd1;
        end
`endif
      end
      TXS_RELEASE: begin
        if (!enc_irq) begin
          if (GAP_LD == 16'd0) begin
            state_d = TXS_IDLE;
          end else begin
            gap_d   = GAP_LD;
            state_d = TXS_GAP;
          end
        end
      end
      TXS_GAP: begin
        gap_d = gap_q - 16'd1;
        if (gap_q <= 16'd1) state_d = TXS_IDLE;
      end
      default: state_d = TXS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= TXS_IDLE;
      start_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      ack_q   <= '0;
`ifdef TX_SCHED_TIMEOUT_EN
      to_q    <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
`ifdef TX_SCHED_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  assign enc_start = start_q;
  assign enc_data  = data_q;
  assign grant_id  = grant_q;
  assign ack       = ack_q;
  assign busy      = (state_q != TXS_IDLE);
`ifdef TX_SCHED_TIMEOUT_EN
  assign err       = err_q;
`else
  // No abort path in this build; the timeout parameter cannot raise err.
  assign err       = (TIMEOUT_CYCLES < 0) ? '1 : '0;
`endif

endmodule

// File: tb/tb_led_tx_scheduler.sv
// Directed bench for led_tx_scheduler: one instance with a 16-cycle gap and
// one with no gap; both use a 100-cycle timeout when TX_SCHED_TIMEOUT_EN is set.
module tb_led_tx_scheduler;
  import led_tx_scheduler_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic [3:0]  req_a = '0, ack_a, err_a;
  logic [63:0] frame_a = {16'hA5A3, 16'hA5A2, 16'hA5A1, 16'hA5A0};
  logic        irq_a = 1'b0, start_a, busy_a;
  logic [15:0] data_a;
  logic [1:0]  gid_a;

  logic [3:0]  req_b = '0, ack_b, err_b;
  logic [63:0] frame_b = {16'hA5A3, 16'hA5A2, 16'hA5A1, 16'hA5A0};
  logic        irq_b = 1'b0, start_b, busy_b;
  logic [15:0] data_b;
  logic [1:0]  gid_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  led_tx_scheduler #(.ID_WIDTH(2), .GAP_CYCLES(16), .TIMEOUT_CYCLES(100)) dut_a (
    .clock(clock), .reset(reset), .req(req_a), .frame_in(frame_a), .ack(ack_a), .err(err_a),
    .enc_start(start_a), .enc_data(data_a), .enc_irq(irq_a), .grant_id(gid_a), .busy(busy_a)
  );

  led_tx_scheduler #(.ID_WIDTH(2), .GAP_CYCLES(0), .TIMEOUT_CYCLES(100)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .frame_in(frame_b), .ack(ack_b), .err(err_b),
    .enc_start(start_b), .enc_data(data_b), .enc_irq(irq_b), .grant_id(gid_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_start_a(input string tag);
    int n = 0;
    while (!start_a && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " start_seen"}, 32'(start_a), 32'd1);
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (busy_a && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " idle_seen"}, 32'(busy_a), 32'd0);
  endtask

  initial begin
    int ids[6] = '{0, 1, 2, 3, 1, 3};
    int last_rise = 0;
    logic [15:0] exp_frame;

    // Reset values
    tick();
    tick();
    chk("rst start", 32'(start_a), 32'd0);
    chk("rst data", 32'(data_a), 32'd0);
    chk("rst ack", 32'(ack_a), 32'd0);
    chk("rst err", 32'(err_a), 32'd0);
    chk("rst gid", 32'(gid_a), 32'd0);
    chk("rst busy", 32'(busy_a), 32'd0);
    reset = 1'b1;
    tick();

    // Single request on req[1]
    req_a = 4'b0010;
    tick();
    chk("t1 start", 32'(start_a), 32'd1);
    chk("t1 data", 32'(data_a), 32'hA5A1);
    chk("t1 gid", 32'(gid_a), 32'd1);
    chk("t1 busy", 32'(busy_a), 32'd1);
    tick(); tick(); tick();
    chk("t1 hold start", 32'(start_a), 32'd1);
    chk("t1 hold data", 32'(data_a), 32'hA5A1);
    irq_a = 1'b1;
    tick();
    chk("t1 ack", 32'(ack_a), 32'b0010);
    chk("t1 start drop", 32'(start_a), 32'd0);
    req_a = 4'b0000;
    irq_a = 1'b0;
    tick();
    chk("t1 ack single", 32'(ack_a), 32'd0);
    repeat (15) tick();
    chk("t1 busy in gap", 32'(busy_a), 32'd1);
    tick();
    chk("t1 busy end", 32'(busy_a), 32'd0);

    // One-cycle request on req[2], frame changed after grant
    req_a = 4'b0100;
    tick();
    chk("t3 gid", 32'(gid_a), 32'd2);
    chk("t3 data", 32'(data_a), 32'hA5A2);
    req_a = 4'b0000;
    frame_a[47:32] = 16'h1234;
    tick(); tick();
    chk("t3 data held", 32'(data_a), 32'hA5A2);
    chk("t3 start held", 32'(start_a), 32'd1);
    irq_a = 1'b1;
    tick();
    chk("t3 ack", 32'(ack_a), 32'b0100);
    irq_a = 1'b0;
    wait_idle_a("t3");

    // Reset in the middle of SEND; pointer returns to 0
    req_a = 4'b0100;
    tick();
    chk("t4 gid", 32'(gid_a), 32'd2);
    chk("t4 data", 32'(data_a), 32'h1234);
    req_a = 4'b1001;
    tick();
    reset = 1'b0;
    #1;
    chk("t4 async start", 32'(start_a), 32'd0);
    chk("t4 async busy", 32'(busy_a), 32'd0);
    chk("t4 async gid", 32'(gid_a), 32'd0);
    tick();
    chk("t4 rst ack", 32'(ack_a), 32'd0);
    chk("t4 rst start", 32'(start_a), 32'd0);
    reset = 1'b1;
    tick();
    chk("t4 regrant gid", 32'(gid_a), 32'd0);
    chk("t4 regrant data", 32'(data_a), 32'hA5A0);
    irq_a = 1'b1;
    tick();
    chk("t4 ack", 32'(ack_a), 32'b0001);
    chk("t4 err", 32'(err_a), 32'd0);
    req_a = 4'b1000;
    irq_a = 1'b0;
    wait_start_a("t4b");
    chk("t4b gid", 32'(gid_a), 32'd3);
    chk("t4b data", 32'(data_a), 32'hA5A3);
    irq_a = 1'b1;
    tick();
    chk("t4b ack", 32'(ack_a), 32'b1000);
    req_a = 4'b0000;
    irq_a = 1'b0;
    wait_idle_a("t4b");

    // Round-robin over all four, then a second batch from the pointer
    req_a = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_start_a($sformatf("rr%0d", k));
      case (ids[k])
        0: exp_frame = 16'hA5A0;
        1: exp_frame = 16'hA5A1;
        2: exp_frame = 16'h1234;
        default: exp_frame = 16'hA5A3;
      endcase
      chk($sformatf("rr%0d gid", k), 32'(gid_a), 32'(ids[k]));
      chk($sformatf("rr%0d data", k), 32'(data_a), 32'(exp_frame));
      // ack lands 3 edges after the rise, then 1 release + 16 gap + 1 idle
      if (k > 0) chk($sformatf("rr%0d spacing", k), 32'(cyc - last_rise), 32'd21);
      last_rise = cyc;
      tick(); tick();
      irq_a = 1'b1;
      tick();
      chk($sformatf("rr%0d ack", k), 32'(ack_a), 32'(4'b0001 << ids[k]));
      req_a[ids[k]] = 1'b0;
      irq_a = 1'b0;
      if (k == 3) req_a = 4'b1010;
    end
    wait_idle_a("rr");

    // Zero gap: re-grant 2 clocks after ack
    req_b = 4'b0011;
    tick();
    chk("g0 gid", 32'(gid_b), 32'd0);
    chk("g0 start", 32'(start_b), 32'd1);
    irq_b = 1'b1;
    tick();
    chk("g0 ack", 32'(ack_b), 32'b0001);
    req_b = 4'b0010;
    irq_b = 1'b0;
    tick();
    chk("g0 start low", 32'(start_b), 32'd0);
    tick();
    chk("g0 restart", 32'(start_b), 32'd1);
    chk("g0 gid2", 32'(gid_b), 32'd1);
    chk("g0 data2", 32'(data_b), 32'hA5A1);

    // Encoder irq stuck low
    repeat (99) tick();
    chk("to pre start", 32'(start_b), 32'd1);
    chk("to pre err", 32'(err_b), 32'd0);
    tick();
`ifdef TX_SCHED_TIMEOUT_EN
    chk("to err", 32'(err_b), 32'b0010);
    chk("to start", 32'(start_b), 32'd0);
    chk("to no ack", 32'(ack_b), 32'd0);
`else
    chk("to start", 32'(start_b), 32'd1);
    chk("to err", 32'(err_b), 32'd0);
    repeat (50) tick();
    chk("to start late", 32'(start_b), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
